// File: rtl/arb_pkg.sv
// Shared definitions for the burst arbiter: width helpers and the opcode
// values that requesters place on the memory request port.
package arb_pkg;

  // Opcodes carried through the arbiter untouched
  localparam logic [2:0] OP_PUT = 3'h2;
  localparam logic [2:0] OP_GET = 3'h4;

  // Ceiling log2 that never returns zero, so a one-channel build still
  // gets a one-bit source field
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of the winning-channel index carried downstream
  function automatic int src_width(input int n);
    return clog2_min1(n);
  endfunction

  // Width of the remaining-beat counter; it holds a raw beats-1 field
  function automatic int beat_cnt_width(input int beat_w);
    return beat_w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating picker: returns the first requesting channel at or after the
// start pointer, wrapping around. A start of zero gives fixed priority.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int SRC_W = src_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SRC_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [SRC_W-1:0] grant_idx
);

  int best_rank;
  int rank;

  // Rank every requester by its distance from the pointer and keep the nearest
  always_comb begin
    best_rank = N;
    rank      = 0;
    grant_idx = '0;
    grant     = '0;
    for (int i = 0; i < N; i++) begin
      rank = (i + N - int'(start)) % N;
      if (req[i] && (rank < best_rank)) begin
        best_rank = rank;
        grant_idx = SRC_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      grant[i] = (best_rank < N) && (grant_idx == SRC_W'(i));
    end
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// N-channel burst arbiter in front of a single memory request port. A
// channel that starts a multi-beat burst holds the grant until its last
// beat has gone out; a single register stage drives the downstream port.
module rr_burst_arbiter
  import arb_pkg::*;
#(
  parameter int N      = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int OP_W   = 3,
  parameter int BEAT_W = 3,
  parameter int RR     = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N-1:0]                io_in_valid,
  output logic [N-1:0]                io_in_ready,
  input  logic [N*OP_W-1:0]           io_in_opcode,
  input  logic [N*ADDR_W-1:0]         io_in_address,
  input  logic [N*DATA_W-1:0]         io_in_data,
  input  logic [N*BEAT_W-1:0]         io_in_beats,
  input  logic                        io_out_ready,
  output logic                        io_out_valid,
  output logic [OP_W-1:0]             io_out_opcode,
  output logic [ADDR_W-1:0]           io_out_address,
  output logic [DATA_W-1:0]           io_out_data,
  output logic [src_width(N)-1:0]     io_out_source,
  output logic                        io_out_last
);

  localparam int SRC_W = src_width(N);
  localparam int CNT_W = beat_cnt_width(BEAT_W);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic [0:0]       state;
  logic [SRC_W-1:0] lock_id;
  logic [CNT_W-1:0] beat_cnt;
  logic [SRC_W-1:0] rr_ptr;

  logic [SRC_W-1:0] pick_start;
  logic [SRC_W-1:0] pick_idx;
  logic [N-1:0]     pick_oh;
  logic [N-1:0]     lock_oh;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W-1:0] next_ptr;
  logic             acc;
  logic             fire;
  logic             last_beat;

  logic [OP_W-1:0]   sel_op;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [BEAT_W-1:0] sel_beats;

  assign pick_start = (RR != 0) ? rr_ptr : '0;

  rr_pick #(
    .N     (N),
    .SRC_W (SRC_W)
  ) u_pick (
    .req       (io_in_valid),
    .start     (pick_start),
    .grant     (pick_oh),
    .grant_idx (pick_idx)
  );

  // Choose the owner of this cycle and raise its ready when the stage can take a beat
  always_comb begin
    acc       = !io_out_valid || io_out_ready;
    lock_oh   = '0;
    for (int i = 0; i < N; i++) begin
      lock_oh[i] = (lock_id == SRC_W'(i));
    end
    grant_idx   = (state == ST_LOCKED) ? lock_id : pick_idx;
    io_in_ready = '0;
    if (!reset && acc) begin
      io_in_ready = (state == ST_LOCKED) ? (lock_oh & io_in_valid) : pick_oh;
    end
    fire     = |io_in_ready;
    next_ptr = (grant_idx == SRC_W'(N - 1)) ? '0 : grant_idx + SRC_W'(1);
  end

  // Route the granted channel's fields and decide whether this beat closes its burst
  always_comb begin
    sel_op    = '0;
    sel_addr  = '0;
    sel_data  = '0;
    sel_beats = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        sel_op    = io_in_opcode[i*OP_W +: OP_W];
        sel_addr  = io_in_address[i*ADDR_W +: ADDR_W];
        sel_data  = io_in_data[i*DATA_W +: DATA_W];
        sel_beats = io_in_beats[i*BEAT_W +: BEAT_W];
      end
    end
    last_beat = (state == ST_LOCKED) ? (beat_cnt == CNT_W'(1)) : (sel_beats == '0);
  end

  // Lock on the first beat of a multi-beat burst, count beats down, advance the pointer when a burst ends
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_UNLOCKED;
      lock_id  <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
    end else if (fire) begin
      if (state == ST_UNLOCKED) begin
        if (sel_beats != '0) begin
          state    <= ST_LOCKED;
          lock_id  <= grant_idx;
          beat_cnt <= CNT_W'(sel_beats);
        end
      end else begin
        beat_cnt <= beat_cnt - CNT_W'(1);
        if (last_beat) begin
          state <= ST_UNLOCKED;
        end
      end
      if (last_beat && (RR != 0)) begin
        rr_ptr <= next_ptr;
      end
    end
  end

  // Output register: load on every accepted beat, hold while downstream stalls
  always_ff @(posedge clock) begin
    if (reset) begin
      io_out_valid   <= 1'b0;
      io_out_opcode  <= '0;
      io_out_address <= '0;
      io_out_data    <= '0;
      io_out_source  <= '0;
      io_out_last    <= 1'b0;
    end else if (fire) begin
      io_out_valid   <= 1'b1;
      io_out_opcode  <= sel_op;
      io_out_address <= sel_addr;
      io_out_data    <= sel_data;
      io_out_source  <= grant_idx;
      io_out_last    <= last_beat;
    end else if (io_out_ready) begin
      io_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Bench for rr_burst_arbiter: a round-robin and a fixed-priority instance
// share one stimulus stream; a transaction-level model tracks both, and
// directed tables and sequences pin down the corner cases.
module tb_rr_burst_arbiter;
  import arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int OW = 3;
  localparam int BW = 3;
  localparam int SW = src_width(N);

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [N-1:0]  in_valid;
  logic          out_ready;
  logic [OW-1:0] ch_op[N];
  logic [AW-1:0] ch_addr[N];
  logic [DW-1:0] ch_data[N];
  logic [BW-1:0] ch_beats[N];

  logic [N*OW-1:0] bus_op;
  logic [N*AW-1:0] bus_addr;
  logic [N*DW-1:0] bus_data;
  logic [N*BW-1:0] bus_beats;

  // Pack the per-channel fields onto the flat request buses
  always_comb begin
    bus_op    = '0;
    bus_addr  = '0;
    bus_data  = '0;
    bus_beats = '0;
    for (int i = 0; i < N; i++) begin
      bus_op[i*OW +: OW]    = ch_op[i];
      bus_addr[i*AW +: AW]  = ch_addr[i];
      bus_data[i*DW +: DW]  = ch_data[i];
      bus_beats[i*BW +: BW] = ch_beats[i];
    end
  end

  logic [N-1:0]  rr_ready, fx_ready;
  logic          rr_ov, fx_ov, rr_last, fx_last;
  logic [OW-1:0] rr_op, fx_op;
  logic [AW-1:0] rr_addr, fx_addr;
  logic [DW-1:0] rr_data, fx_data;
  logic [SW-1:0] rr_src, fx_src;

  rr_burst_arbiter #(.N(N), .ADDR_W(AW), .DATA_W(DW), .OP_W(OW), .BEAT_W(BW), .RR(1)) dut_rr (
    .clock(clock), .reset(reset), .io_in_valid(in_valid), .io_in_ready(rr_ready),
    .io_in_opcode(bus_op), .io_in_address(bus_addr), .io_in_data(bus_data), .io_in_beats(bus_beats),
    .io_out_ready(out_ready), .io_out_valid(rr_ov), .io_out_opcode(rr_op), .io_out_address(rr_addr),
    .io_out_data(rr_data), .io_out_source(rr_src), .io_out_last(rr_last)
  );

  rr_burst_arbiter #(.N(N), .ADDR_W(AW), .DATA_W(DW), .OP_W(OW), .BEAT_W(BW), .RR(0)) dut_fx (
    .clock(clock), .reset(reset), .io_in_valid(in_valid), .io_in_ready(fx_ready),
    .io_in_opcode(bus_op), .io_in_address(bus_addr), .io_in_data(bus_data), .io_in_beats(bus_beats),
    .io_out_ready(out_ready), .io_out_valid(fx_ov), .io_out_opcode(fx_op), .io_out_address(fx_addr),
    .io_out_data(fx_data), .io_out_source(fx_src), .io_out_last(fx_last)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per instance, the burst owner (-1 = none), beats still
  // owed after the one just sent, the round-robin start, and the held beat
  typedef struct {
    logic          valid;
    logic [OW-1:0] op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] src;
    logic          last;
  } beat_t;

  int    m_owner[2];
  int    m_left[2];
  int    m_ptr[2];
  beat_t m_out[2];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of the model for instance m (0 = round-robin, 1 = fixed)
  task automatic modelStep(input int m, output logic [N-1:0] exp_ready);
    int    g;
    int    start;
    int    c;
    logic  accept;
    exp_ready = '0;
    g         = -1;
    if (reset) begin
      m_owner[m]     = -1;
      m_left[m]      = 0;
      m_ptr[m]       = 0;
      m_out[m].valid = 1'b0;
      m_out[m].op    = '0;
      m_out[m].addr  = '0;
      m_out[m].data  = '0;
      m_out[m].src   = '0;
      m_out[m].last  = 1'b0;
      return;
    end
    accept = !m_out[m].valid || out_ready;
    if (m_owner[m] >= 0) begin
      if (in_valid[m_owner[m][1:0]]) g = m_owner[m];
    end else begin
      start = (m == 0) ? m_ptr[m] : 0;
      for (int k = 0; k < N; k++) begin
        c = (start + k) % N;
        if (g < 0 && in_valid[c[1:0]]) g = c;
      end
    end
    if (accept && g >= 0) begin
      exp_ready[g[1:0]] = 1'b1;
      if (m_owner[m] < 0) begin
        m_left[m] = int'(ch_beats[g[1:0]]);
        if (m_left[m] > 0) m_owner[m] = g;
      end else begin
        m_left[m] = m_left[m] - 1;
        if (m_left[m] == 0) m_owner[m] = -1;
      end
      m_out[m].valid = 1'b1;
      m_out[m].op    = ch_op[g[1:0]];
      m_out[m].addr  = ch_addr[g[1:0]];
      m_out[m].data  = ch_data[g[1:0]];
      m_out[m].src   = g[1:0];
      m_out[m].last  = (m_left[m] == 0);
      if (m_left[m] == 0 && m == 0) m_ptr[m] = (g + 1) % N;
    end else if (out_ready) begin
      m_out[m].valid = 1'b0;
    end
  endtask

  task automatic compareModel();
    checkOutput("rr_out_valid", 128'(rr_ov), 128'(m_out[0].valid));
    if (m_out[0].valid)
      checkOutput("rr_payload", 128'({rr_op, rr_addr, rr_data, rr_src, rr_last}),
                  128'({m_out[0].op, m_out[0].addr, m_out[0].data, m_out[0].src, m_out[0].last}));
    checkOutput("fx_out_valid", 128'(fx_ov), 128'(m_out[1].valid));
    if (m_out[1].valid)
      checkOutput("fx_payload", 128'({fx_op, fx_addr, fx_data, fx_src, fx_last}),
                  128'({m_out[1].op, m_out[1].addr, m_out[1].data, m_out[1].src, m_out[1].last}));
  endtask

  // Drive one cycle: inputs, ready check before the edge, outputs after it
  task automatic applyStimulus(input logic rst, input logic [N-1:0] v, input logic ordy,
                               output logic [N-1:0] rdy_rr, output logic [N-1:0] rdy_fx);
    logic [N-1:0] er0, er1;
    reset     = rst;
    in_valid  = v;
    out_ready = ordy;
    #1;
    rdy_rr = rr_ready;
    rdy_fx = fx_ready;
    modelStep(0, er0);
    modelStep(1, er1);
    checkOutput("rr_ready_model", 128'(rr_ready), 128'(er0));
    checkOutput("fx_ready_model", 128'(fx_ready), 128'(er1));
    @(posedge clock);
    #1;
    compareModel();
  endtask

  task automatic setChannels(input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                             input logic [BW-1:0] b2, input logic [BW-1:0] b3);
    for (int i = 0; i < N; i++) begin
      ch_op[i]   = (i % 2 == 0) ? OP_PUT : OP_GET;
      ch_addr[i] = 32'h100 * (i + 1);
      ch_data[i] = 32'hD000_0000 + i;
    end
    ch_beats[0] = b0;
    ch_beats[1] = b1;
    ch_beats[2] = b2;
    ch_beats[3] = b3;
  endtask

  typedef struct {
    logic [N-1:0]  valid;
    logic [BW-1:0] beats2;
    logic          ordy;
    logic [N-1:0]  exp_ready;
    logic          exp_ov;
    logic [SW-1:0] exp_src;
    logic          exp_last;
  } vec_t;

  vec_t vecs[12];

  logic [N-1:0] r0, r1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    // Round-robin rotation, then a 4-beat burst from ch2 with ch0 waiting
    vecs[0]  = '{4'b1111, 3'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    vecs[1]  = '{4'b1111, 3'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    vecs[2]  = '{4'b1111, 3'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
    vecs[3]  = '{4'b1111, 3'd0, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
    vecs[4]  = '{4'b1111, 3'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    vecs[5]  = '{4'b0101, 3'd3, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
    vecs[6]  = '{4'b0101, 3'd5, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
    vecs[7]  = '{4'b0101, 3'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
    vecs[8]  = '{4'b0101, 3'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
    vecs[9]  = '{4'b0101, 3'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    vecs[10] = '{4'b0000, 3'd0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[11] = '{4'b0000, 3'd0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};

    setChannels(0, 0, 0, 0);
    reset = 1'b1; in_valid = '0; out_ready = 1'b1;
    @(posedge clock); #1;
    applyStimulus(1'b1, '0, 1'b1, r0, r1);
    checkOutput("reset_out_valid", 128'({rr_ov, fx_ov}), 128'(2'b00));
    checkOutput("reset_payload", 128'({rr_op, rr_addr, rr_data, rr_src, rr_last}), 128'(0));

    $display("[TB] table: rotation and ch2 burst");
    for (int t = 0; t < 12; t++) begin
      setChannels(0, 0, vecs[t].beats2, 0);
      applyStimulus(1'b0, vecs[t].valid, vecs[t].ordy, r0, r1);
      checkOutput($sformatf("tbl%0d_ready", t), 128'(r0), 128'(vecs[t].exp_ready));
      checkOutput($sformatf("tbl%0d_valid", t), 128'(rr_ov), 128'(vecs[t].exp_ov));
      if (vecs[t].exp_ov) begin
        checkOutput($sformatf("tbl%0d_src", t), 128'(rr_src), 128'(vecs[t].exp_src));
        checkOutput($sformatf("tbl%0d_last", t), 128'(rr_last), 128'(vecs[t].exp_last));
        checkOutput($sformatf("tbl%0d_addr", t), 128'(rr_addr), 128'(32'h100 * (vecs[t].exp_src + 1)));
      end
    end

    $display("[TB] fixed priority: ch1 beats ch3");
    applyStimulus(1'b1, '0, 1'b1, r0, r1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 4'b1010, 1'b1, r0, r1);
      checkOutput("fx_ch1_wins", 128'(r1), 128'(4'b0010));
      checkOutput("fx_src1", 128'(fx_src), 128'(2'd1));
    end
    applyStimulus(1'b0, 4'b1000, 1'b1, r0, r1);
    checkOutput("fx_ch3_after_drop", 128'(r1), 128'(4'b1000));

    $display("[TB] downstream stall holds the beat");
    applyStimulus(1'b1, '0, 1'b1, r0, r1);
    setChannels(0, 0, 0, 0);
    ch_addr[0] = 32'h1000;
    applyStimulus(1'b0, 4'b0001, 1'b0, r0, r1);
    checkOutput("stall_first_ready", 128'(r0), 128'(4'b0001));
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 4'b0010, 1'b0, r0, r1);
      checkOutput("stall_ready_low", 128'(r0), 128'(4'b0000));
      checkOutput("stall_held", 128'({rr_ov, rr_addr, rr_src}), 128'({1'b1, 32'h1000, 2'd0}));
    end
    applyStimulus(1'b0, 4'b0000, 1'b1, r0, r1);
    checkOutput("stall_delivered_once", 128'(rr_ov), 128'(1'b0));

    $display("[TB] locked channel pauses mid-burst");
    applyStimulus(1'b1, '0, 1'b1, r0, r1);
    setChannels(0, 3, 0, 0);
    applyStimulus(1'b0, 4'b0010, 1'b1, r0, r1);
    checkOutput("pause_beat1_ready", 128'(r0), 128'(4'b0010));
    ch_addr[1] = 32'h101; ch_beats[1] = 3'd0;
    applyStimulus(1'b0, 4'b0010, 1'b1, r0, r1);
    checkOutput("pause_beat2_ready", 128'(r0), 128'(4'b0010));
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 4'b0101, 1'b1, r0, r1);
      checkOutput("pause_no_grant", 128'(r0), 128'(4'b0000));
    end
    checkOutput("pause_out_idle", 128'(rr_ov), 128'(1'b0));
    ch_addr[1] = 32'h102;
    applyStimulus(1'b0, 4'b0111, 1'b1, r0, r1);
    checkOutput("resume_beat3", 128'({r0, rr_src, rr_addr, rr_last}), 128'({4'b0010, 2'd1, 32'h102, 1'b0}));
    ch_addr[1] = 32'h103;
    applyStimulus(1'b0, 4'b0111, 1'b1, r0, r1);
    checkOutput("resume_beat4", 128'({r0, rr_src, rr_addr, rr_last}), 128'({4'b0010, 2'd1, 32'h103, 1'b1}));
    applyStimulus(1'b0, 4'b0101, 1'b1, r0, r1);
    checkOutput("after_burst_next", 128'(r0), 128'(4'b0100));

    $display("[TB] reset in the middle of a burst");
    setChannels(0, 3, 0, 0);
    applyStimulus(1'b0, 4'b0010, 1'b1, r0, r1);
    checkOutput("rst_beat1_ready", 128'(r0), 128'(4'b0010));
    applyStimulus(1'b1, 4'b0010, 1'b1, r0, r1);
    checkOutput("rst_out_cleared", 128'(rr_ov), 128'(1'b0));
    setChannels(0, 0, 0, 0);
    applyStimulus(1'b0, 4'b1010, 1'b1, r0, r1);
    checkOutput("rst_ptr_zero", 128'(r0), 128'(4'b0010));
    applyStimulus(1'b0, 4'b1000, 1'b1, r0, r1);
    checkOutput("rst_ch3_ready", 128'(r0), 128'(4'b1000));
    checkOutput("rst_ch3_out", 128'({rr_ov, rr_src, rr_last}), 128'({1'b1, 2'd3, 1'b1}));

    $display("[TB] randomized traffic against the model");
    applyStimulus(1'b1, '0, 1'b1, r0, r1);
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) begin
        ch_op[i]    = ($urandom_range(1) == 0) ? OP_PUT : OP_GET;
        ch_addr[i]  = $urandom;
        ch_data[i]  = $urandom;
        ch_beats[i] = 3'($urandom_range(3));
      end
      applyStimulus(($urandom_range(63) == 0), 4'($urandom | $urandom), ($urandom_range(3) != 0), r0, r1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
